// File: rtl/mirfak_id_stage_hs.sv
// mirfak_id_stage_hs
// Handshaked instruction-decode stage between IF and EX. It reads the register
// file, resolves operand forwarding from NFWD sources, builds immediates and
// operands, and resolves branches/jumps in ID. A 2-entry skid buffer (OUT + SKID)
// sits in front of EX, so back-pressure never drops or duplicates an instruction.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   id_valid_i / id_ready_o           IF -> ID handshake (ready is registered)
//   id_pc_i, id_pc4_i, id_instruction_i, id_if_exception_i, id_if_xcause_i,
//   id_bubble_i, id_control_i         incoming instruction payload
//   rf_raddr_a_o/b_o, rf_rdata_a_i/b_i register file read port (same cycle)
//   id_fwd_a_sel_i/b_sel_i, fwd_data_i forwarding selects and source data
//   flush_i                           drop held and incoming instructions
//   take_branch_o, pc_bj_target_o     combinational redirect to IF
//   ex_valid_o / ex_ready_i           ID -> EX handshake
//   ex_*                              registered payload towards EX
//
// Control word layout (bit positions inside id_control_i).
`ifndef MIRFAK_ID_DEFS
`define MIRFAK_ID_DEFS
`define CTRL_SZ                16
`define CTRL_SEL_IMM           2:0
`define CTRL_SEL_A             4:3
`define CTRL_SEL_B             6:5
`define CTRL_BEQ               7
`define CTRL_BNE               8
`define CTRL_BLT               9
`define CTRL_BGE               10
`define CTRL_BLTU              11
`define CTRL_BGEU              12
`define CTRL_IS_J              13
`define CTRL_INVALID           14
`define A_RF                   2'd0
`define A_PC                   2'd1
`define A_PC4                  2'd2
`define A_ZERO                 2'd3
`define B_RF                   2'd0
`define B_IMM                  2'd1
`define B_4                    2'd2
`define B_ZERO                 2'd3
`define E_INST_ADDR_MISALIGNED 4'd0
`define E_ILLEGAL_INST         4'd2
`endif

module mirfak_id_stage_hs #(
  parameter int NFWD  = 2,
  parameter int C_EXT = 0,
  localparam int FW   = $clog2(NFWD + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  logic [31:0]            id_pc_i,
  input  logic [31:0]            id_pc4_i,
  input  logic [31:0]            id_instruction_i,
  input  logic                   id_if_exception_i,
  input  logic [3:0]             id_if_xcause_i,
  input  logic                   id_bubble_i,
  input  logic [`CTRL_SZ-1:0]    id_control_i,
  output logic [4:0]             rf_raddr_a_o,
  output logic [4:0]             rf_raddr_b_o,
  input  logic [31:0]            rf_rdata_a_i,
  input  logic [31:0]            rf_rdata_b_i,
  input  logic [FW-1:0]          id_fwd_a_sel_i,
  input  logic [FW-1:0]          id_fwd_b_sel_i,
  input  logic [32*NFWD-1:0]     fwd_data_i,
  input  logic                   flush_i,
  output logic                   take_branch_o,
  output logic [31:0]            pc_bj_target_o,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [31:0]            ex_pc_o,
  output logic [31:0]            ex_pc4_o,
  output logic [31:0]            ex_instruction_o,
  output logic [31:0]            ex_mtval_o,
  output logic [31:0]            ex_operand_a_o,
  output logic [31:0]            ex_operand_b_o,
  output logic [31:0]            ex_lsu_wdata_o,
  output logic                   ex_exception_o,
  output logic [3:0]             ex_xcause_o,
  output logic                   ex_bubble_o,
  output logic [`CTRL_SZ-1:0]    ex_control_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          pc4;
    logic [31:0]          instruction;
    logic [31:0]          mtval;
    logic [31:0]          operand_a;
    logic [31:0]          operand_b;
    logic [31:0]          lsu_wdata;
    logic                 exception;
    logic [3:0]           xcause;
    logic                 bubble;
    logic [`CTRL_SZ-1:0]  control;
  } beat_t;

  state_e      state_q, state_n;
  logic        id_ready_q;
  logic        accept;
  logic        load_out_new, load_out_skid, load_skid;
  logic [31:0] fwd_a, fwd_b;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic        br_cond, bj_error, is_jalr;
  logic [31:0] target;
  beat_t       new_beat, out_q, skid_q;

  assign accept       = id_valid_i & id_ready_q & ~flush_i;
  assign rf_raddr_a_o = id_instruction_i[19:15];
  assign rf_raddr_b_o = id_instruction_i[24:20];

  // Forwarding selects beyond the last source yield zero rather than X.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (id_fwd_a_sel_i == '0) fwd_a = rf_rdata_a_i;
    if (id_fwd_b_sel_i == '0) fwd_b = rf_rdata_b_i;
    for (int k = 1; k <= NFWD; k++) begin
      if (id_fwd_a_sel_i == FW'(k)) fwd_a = fwd_data_i[32*k-1 -: 32];
      if (id_fwd_b_sel_i == FW'(k)) fwd_b = fwd_data_i[32*k-1 -: 32];
    end
  end

  assign imm_i = {{20{id_instruction_i[31]}}, id_instruction_i[31:20]};
  assign imm_s = {{20{id_instruction_i[31]}}, id_instruction_i[31:25], id_instruction_i[11:7]};
  assign imm_b = {{19{id_instruction_i[31]}}, id_instruction_i[31], id_instruction_i[7],
                  id_instruction_i[30:25], id_instruction_i[11:8], 1'b0};
  assign imm_u = {id_instruction_i[31:12], 12'h000};
  assign imm_j = {{11{id_instruction_i[31]}}, id_instruction_i[31], id_instruction_i[19:12],
                  id_instruction_i[20], id_instruction_i[30:21], 1'b0};

  // Immediate select, branch resolution and exception priority for the beat
  // being offered this cycle. JALR is the jump whose opcode has bit 3 clear.
  always_comb begin
    case (id_control_i[`CTRL_SEL_IMM])
      3'b000:  imm_sel = imm_i;
      3'b001:  imm_sel = imm_s;
      3'b010:  imm_sel = imm_b;
      3'b011:  imm_sel = imm_u;
      3'b100:  imm_sel = imm_j;
      default: imm_sel = '0;
    endcase

    br_cond = (id_control_i[`CTRL_BEQ]  &  (fwd_a == fwd_b)) |
              (id_control_i[`CTRL_BNE]  & ~(fwd_a == fwd_b)) |
              (id_control_i[`CTRL_BLT]  &  ($signed(fwd_a) < $signed(fwd_b))) |
              (id_control_i[`CTRL_BGE]  & ~($signed(fwd_a) < $signed(fwd_b))) |
              (id_control_i[`CTRL_BLTU] &  (fwd_a < fwd_b)) |
              (id_control_i[`CTRL_BGEU] & ~(fwd_a < fwd_b)) |
              id_control_i[`CTRL_IS_J];

    is_jalr = id_control_i[`CTRL_IS_J] & ~id_instruction_i[3];
    if (is_jalr) target = (fwd_a + imm_i) & 32'hFFFF_FFFE;
    else         target = id_pc_i + (id_control_i[`CTRL_IS_J] ? imm_j : imm_b);

    take_branch_o = br_cond & accept;
    bj_error      = take_branch_o & (|target[1:0]) & (C_EXT == 0);

    new_beat             = '0;
    new_beat.pc          = id_pc_i;
    new_beat.pc4         = id_pc4_i;
    new_beat.instruction = id_instruction_i;
    new_beat.bubble      = id_bubble_i;
    new_beat.control     = id_control_i;
    new_beat.lsu_wdata   = fwd_b;
    case (id_control_i[`CTRL_SEL_A])
      `A_RF:   new_beat.operand_a = fwd_a;
      `A_PC:   new_beat.operand_a = id_pc_i;
      `A_PC4:  new_beat.operand_a = id_pc4_i;
      default: new_beat.operand_a = '0;
    endcase
    case (id_control_i[`CTRL_SEL_B])
      `B_RF:   new_beat.operand_b = fwd_b;
      `B_IMM:  new_beat.operand_b = imm_sel;
      `B_4:    new_beat.operand_b = 32'd4;
      default: new_beat.operand_b = '0;
    endcase
    new_beat.exception = id_if_exception_i | id_control_i[`CTRL_INVALID] | bj_error;
    if (id_if_exception_i) begin
      new_beat.xcause = id_if_xcause_i;
      new_beat.mtval  = id_pc_i;
    end else if (bj_error) begin
      new_beat.xcause = `E_INST_ADDR_MISALIGNED;
      new_beat.mtval  = target;
    end else if (id_control_i[`CTRL_INVALID]) begin
      new_beat.xcause = `E_ILLEGAL_INST;
      new_beat.mtval  = id_instruction_i;
    end
  end

  assign pc_bj_target_o = target;

  // Skid-buffer occupancy: flush empties everything; in FULL nothing can be
  // accepted because id_ready_o is already low.
  always_comb begin
    state_n       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_n      = ONE;
          load_out_new = 1'b1;
        end
        ONE: begin
          if (accept && ex_ready_i) begin
            load_out_new = 1'b1;
          end else if (accept) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (ex_ready_i) begin
            state_n = EMPTY;
          end
        end
        FULL: if (ex_ready_i) begin
          state_n       = ONE;
          load_out_skid = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // State register; ready is registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      id_ready_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      id_ready_q <= (state_n != FULL);
    end
  end

  // Payload registers; reset presents a NOP bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q              <= '0;
      out_q.instruction  <= 32'h0000_0013;
      out_q.bubble       <= 1'b1;
      skid_q             <= '0;
      skid_q.instruction <= 32'h0000_0013;
      skid_q.bubble      <= 1'b1;
    end else begin
      if (load_skid)          skid_q <= new_beat;
      if (load_out_new)       out_q  <= new_beat;
      else if (load_out_skid) out_q  <= skid_q;
    end
  end

  assign id_ready_o       = id_ready_q;
  assign ex_valid_o       = (state_q != EMPTY);
  assign ex_pc_o          = out_q.pc;
  assign ex_pc4_o         = out_q.pc4;
  assign ex_instruction_o = out_q.instruction;
  assign ex_mtval_o       = out_q.mtval;
  assign ex_operand_a_o   = out_q.operand_a;
  assign ex_operand_b_o   = out_q.operand_b;
  assign ex_lsu_wdata_o   = out_q.lsu_wdata;
  assign ex_exception_o   = out_q.exception;
  assign ex_xcause_o      = out_q.xcause;
  assign ex_bubble_o      = out_q.bubble;
  assign ex_control_o     = out_q.control;

endmodule

// File: tb/tb_mirfak_id_stage_hs.sv
// tb_mirfak_id_stage_hs
// Drives two instances of mirfak_id_stage_hs (C_EXT = 0 and 1) with the same
// stimulus: directed scenarios with literal expectations, then random traffic.
// A behavioural model keeps a queue of the beats held by the stage and derives
// the expected outputs from the instruction semantics.
module tb_mirfak_id_stage_hs;
  localparam int NFWD = 2;
  localparam int FW   = 2;
  localparam int CW   = 16;
  localparam int C_BEQ = 7, C_J = 13, C_INV = 14;
  localparam logic [3:0] E_MIS = 4'd0, E_ILL = 4'd2;

  typedef struct {
    logic [31:0] pc, pc4, instr, mtval, opa, opb, wdata;
    logic        exc;
    logic [3:0]  cause;
    logic        bubble;
    logic [CW-1:0] ctrl;
  } beat_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_if_exc, id_bubble, flush, ex_ready;
  logic [31:0] id_pc, id_pc4, id_instr, rf_a, rf_b, src1, src2;
  logic [3:0]  id_if_xcause;
  logic [CW-1:0] id_ctrl;
  logic [FW-1:0] sel_a, sel_b;
  logic [32*NFWD-1:0] fwd_data;
  assign fwd_data = {src2, src1};

  logic        o_ready[2], o_take[2], o_valid[2], o_exc[2], o_bubble[2];
  logic [4:0]  o_ra[2], o_rb[2];
  logic [31:0] o_tgt[2], o_pc[2], o_pc4[2], o_instr[2], o_mtval[2];
  logic [31:0] o_opa[2], o_opb[2], o_wdata[2];
  logic [3:0]  o_cause[2];
  logic [CW-1:0] o_ctrl[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mirfak_id_stage_hs #(.NFWD(NFWD), .C_EXT(g)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_valid_i(id_valid), .id_ready_o(o_ready[g]),
      .id_pc_i(id_pc), .id_pc4_i(id_pc4), .id_instruction_i(id_instr),
      .id_if_exception_i(id_if_exc), .id_if_xcause_i(id_if_xcause),
      .id_bubble_i(id_bubble), .id_control_i(id_ctrl),
      .rf_raddr_a_o(o_ra[g]), .rf_raddr_b_o(o_rb[g]),
      .rf_rdata_a_i(rf_a), .rf_rdata_b_i(rf_b),
      .id_fwd_a_sel_i(sel_a), .id_fwd_b_sel_i(sel_b), .fwd_data_i(fwd_data),
      .flush_i(flush),
      .take_branch_o(o_take[g]), .pc_bj_target_o(o_tgt[g]),
      .ex_valid_o(o_valid[g]), .ex_ready_i(ex_ready),
      .ex_pc_o(o_pc[g]), .ex_pc4_o(o_pc4[g]), .ex_instruction_o(o_instr[g]),
      .ex_mtval_o(o_mtval[g]), .ex_operand_a_o(o_opa[g]), .ex_operand_b_o(o_opb[g]),
      .ex_lsu_wdata_o(o_wdata[g]), .ex_exception_o(o_exc[g]),
      .ex_xcause_o(o_cause[g]), .ex_bubble_o(o_bubble[g]), .ex_control_o(o_ctrl[g])
    );
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit sb_en = 1'b0;
  bit ready_m = 1'b1;
  beat_t q0[$], q1[$];
  logic [31:0] seen[$];

  task automatic checkOutput(string name, int g, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Reference forwarding: 0 = register file, 1..NFWD = source, beyond = zero.
  function automatic logic [31:0] fwd_val(logic [FW-1:0] sel, logic [31:0] rf);
    case (int'(sel))
      0:       return rf;
      1:       return src1;
      2:       return src2;
      default: return 32'h0;
    endcase
  endfunction

  // RV32I immediates, built from the encoded field positions.
  function automatic logic [31:0] imm_of(logic [31:0] ins, int kind);
    int v;
    case (kind)
      0: v = $signed(ins[31:20]);
      1: v = $signed({ins[31:25], ins[11:7]});
      2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3: v = int'({ins[31:12], 12'h000});
      4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic void calc_branch(output bit cond, output logic [31:0] tgt);
    logic [31:0] a, b;
    a = fwd_val(sel_a, rf_a);
    b = fwd_val(sel_b, rf_b);
    cond = (id_ctrl[C_BEQ]   && a == b) || (id_ctrl[C_BEQ+1] && a != b) ||
           (id_ctrl[C_BEQ+2] && $signed(a) <  $signed(b)) ||
           (id_ctrl[C_BEQ+3] && $signed(a) >= $signed(b)) ||
           (id_ctrl[C_BEQ+4] && a < b) || (id_ctrl[C_BEQ+5] && a >= b) || id_ctrl[C_J];
    if (id_ctrl[C_J] && !id_instr[3]) tgt = (a + imm_of(id_instr, 0)) & 32'hFFFF_FFFE;
    else tgt = id_pc + imm_of(id_instr, id_ctrl[C_J] ? 4 : 2);
  endfunction

  function automatic beat_t expect_beat(int cext);
    beat_t r;
    bit cond, mis;
    logic [31:0] tgt, a, b;
    calc_branch(cond, tgt);
    a = fwd_val(sel_a, rf_a);
    b = fwd_val(sel_b, rf_b);
    r.pc = id_pc; r.pc4 = id_pc4; r.instr = id_instr; r.bubble = id_bubble; r.ctrl = id_ctrl;
    r.wdata = b;
    case (int'(id_ctrl[4:3])) 0: r.opa = a; 1: r.opa = id_pc; 2: r.opa = id_pc4; default: r.opa = 0; endcase
    case (int'(id_ctrl[6:5])) 0: r.opb = b; 1: r.opb = imm_of(id_instr, int'(id_ctrl[2:0]));
      2: r.opb = 4; default: r.opb = 0; endcase
    mis = cond && (tgt % 4 != 0) && cext == 0;
    r.exc = id_if_exc || id_ctrl[C_INV] || mis;
    r.cause = 0; r.mtval = 0;
    if (id_if_exc) begin r.cause = id_if_xcause; r.mtval = id_pc; end
    else if (mis) begin r.cause = E_MIS; r.mtval = tgt; end
    else if (id_ctrl[C_INV]) begin r.cause = E_ILL; r.mtval = id_instr; end
    return r;
  endfunction

  // Model of the stage contents: a queue of at most two beats.
  always @(posedge clk) begin
    if (rst || flush) begin
      q0.delete(); q1.delete(); ready_m = 1'b1;
    end else begin
      bit acc;
      acc = id_valid && ready_m;
      if (ex_ready && q0.size() > 0) begin void'(q0.pop_front()); void'(q1.pop_front()); end
      if (acc) begin q0.push_back(expect_beat(0)); q1.push_back(expect_beat(1)); end
      ready_m = q0.size() < 2;
    end
  end

  // Compare process: checks both instances against the model every cycle.
  always @(negedge clk) begin
    if (!rst && sb_en) begin
      bit cond, exp_take;
      logic [31:0] tgt;
      beat_t b;
      calc_branch(cond, tgt);
      exp_take = id_valid && ready_m && !flush && cond;
      for (int g = 0; g < 2; g++) begin
        checkOutput("id_ready", g, o_ready[g], ready_m);
        checkOutput("ex_valid", g, o_valid[g], q0.size() > 0);
        checkOutput("take_branch", g, o_take[g], exp_take);
        if (exp_take) checkOutput("target", g, o_tgt[g], tgt);
        checkOutput("raddr_a", g, o_ra[g], id_instr[19:15]);
        checkOutput("raddr_b", g, o_rb[g], id_instr[24:20]);
        if (q0.size() > 0) begin
          b = (g == 0) ? q0[0] : q1[0];
          checkOutput("ex_pc", g, o_pc[g], b.pc);
          checkOutput("ex_pc4", g, o_pc4[g], b.pc4);
          checkOutput("ex_instr", g, o_instr[g], b.instr);
          checkOutput("ex_mtval", g, o_mtval[g], b.mtval);
          checkOutput("ex_opa", g, o_opa[g], b.opa);
          checkOutput("ex_opb", g, o_opb[g], b.opb);
          checkOutput("ex_wdata", g, o_wdata[g], b.wdata);
          checkOutput("ex_exc", g, o_exc[g], b.exc);
          checkOutput("ex_cause", g, o_cause[g], b.cause);
          checkOutput("ex_bubble", g, o_bubble[g], b.bubble);
          checkOutput("ex_ctrl", g, o_ctrl[g], b.ctrl);
        end
      end
      if (o_valid[0] && ex_ready) seen.push_back(o_instr[0]);
    end
  end

  function automatic logic [CW-1:0] mk_ctrl(int imm, int sa, int sb, int br, bit inv);
    logic [CW-1:0] c;
    c = '0;
    c[2:0] = imm[2:0]; c[4:3] = sa[1:0]; c[6:5] = sb[1:0];
    if (br > 0) c[6+br] = 1'b1;
    c[C_INV] = inv;
    return c;
  endfunction

  task automatic applyStimulus(bit v, logic [31:0] pc, logic [31:0] ins, logic [CW-1:0] c);
    id_valid = v; id_pc = pc; id_pc4 = pc + 4; id_instr = ins; id_ctrl = c;
    id_if_exc = 0; id_if_xcause = 0; id_bubble = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; ex_ready = 0; rf_a = 0; rf_b = 0; src1 = 0; src2 = 0; sel_a = 0; sel_b = 0;
    applyStimulus(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("rst_valid", 0, o_valid[0], 0);
    checkOutput("rst_ready", 0, o_ready[0], 1);
    checkOutput("rst_instr", 0, o_instr[0], 32'h0000_0013);
    checkOutput("rst_bubble", 0, o_bubble[0], 1);
    checkOutput("rst_opb", 0, o_opb[0], 0);
    checkOutput("rst_exc", 0, o_exc[0], 0);
    sb_en = 1;

    // ADDI x1,x0,5
    tick();
    ex_ready = 1;
    applyStimulus(1, 32'h0, 32'h0050_0093, mk_ctrl(0, 0, 1, 0, 0));
    tick();
    id_valid = 0;
    @(negedge clk);
    checkOutput("addi_valid", 0, o_valid[0], 1);
    checkOutput("addi_opb", 0, o_opb[0], 5);
    checkOutput("addi_bubble", 0, o_bubble[0], 0);

    // Three back-to-back beats with EX stalled for two cycles.
    tick();
    seen.delete();
    applyStimulus(1, 32'h10, 32'h0010_0113, '0); ex_ready = 1;
    tick();
    applyStimulus(1, 32'h14, 32'h0020_0193, '0); ex_ready = 0;
    tick();
    applyStimulus(1, 32'h18, 32'h0030_0213, '0); ex_ready = 0;
    @(negedge clk);
    checkOutput("stall_ready", 0, o_ready[0], 0);
    tick();
    ex_ready = 1;
    begin
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        if (ready_m) done = 1;
        tick();
      end
      if (!done) begin total++; bad++; $display("[TB] FAIL accept_timeout"); end
    end
    id_valid = 0;
    repeat (4) tick();
    checkOutput("seen_len", 0, seen.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput("seen_order", 0, (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF, 32'h0010_0113 + (i << 20) + (i << 7));

    // BEQ via forwarding, pc 0x100, imm_b = +8.
    applyStimulus(1, 32'h100, 32'h0000_0463, mk_ctrl(2, 0, 0, 1, 0));
    sel_a = 1; sel_b = 2; src1 = 7; src2 = 7;
    @(negedge clk);
    checkOutput("beq_take", 0, o_take[0], 1);
    checkOutput("beq_target", 0, o_tgt[0], 32'h108);
    tick();
    src2 = 8;
    @(negedge clk);
    checkOutput("beq_nottaken", 0, o_take[0], 0);
    tick();

    // JALR to 0x203 -> 0x202, misaligned unless compressed is enabled.
    applyStimulus(1, 32'h40, 32'h0000_0067, mk_ctrl(0, 0, 0, 7, 0));
    sel_a = 1; src1 = 32'h203;
    @(negedge clk);
    checkOutput("jalr_take", 0, o_take[0], 1);
    checkOutput("jalr_target", 0, o_tgt[0], 32'h202);
    tick();
    id_valid = 0;
    @(negedge clk);
    checkOutput("jalr_exc", 0, o_exc[0], 1);
    checkOutput("jalr_cause", 0, o_cause[0], E_MIS);
    checkOutput("jalr_mtval", 0, o_mtval[0], 32'h202);
    checkOutput("jalr_cext_exc", 1, o_exc[1], 0);

    // Fill to FULL, then flush with a jump offered.
    repeat (2) tick();
    sel_a = 0; sel_b = 0;
    applyStimulus(1, 32'h80, 32'h0000_0013, '0); ex_ready = 0;
    tick();
    applyStimulus(1, 32'h84, 32'h0000_0013, '0);
    tick();
    applyStimulus(1, 32'h88, 32'h0000_006F, mk_ctrl(4, 0, 0, 7, 0));
    flush = 1;
    @(negedge clk);
    checkOutput("flush_take", 0, o_take[0], 0);
    checkOutput("flush_full_ready", 0, o_ready[0], 0);
    tick();
    flush = 0; id_valid = 0;
    @(negedge clk);
    checkOutput("flush_valid", 0, o_valid[0], 0);
    checkOutput("flush_ready", 0, o_ready[0], 1);

    // Fetch exception beats an illegal control word.
    tick();
    ex_ready = 1;
    applyStimulus(1, 32'h300, 32'hFFFF_FFFF, mk_ctrl(0, 0, 0, 0, 1));
    id_if_exc = 1; id_if_xcause = 4'h1;
    tick();
    id_valid = 0;
    @(negedge clk);
    checkOutput("fetch_exc", 0, o_exc[0], 1);
    checkOutput("fetch_cause", 0, o_cause[0], 4'h1);
    checkOutput("fetch_mtval", 0, o_mtval[0], 32'h300);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst       = ($urandom_range(0, 499) == 0);
      ex_ready  = ($urandom_range(0, 9) < 6);
      applyStimulus($urandom_range(0, 9) < 7,
                    ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                    $urandom,
                    mk_ctrl($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 7), $urandom_range(0, 9) == 0));
      id_ctrl[15]  = $urandom_range(0, 1);
      flush        = ($urandom_range(0, 19) == 0);
      id_if_exc    = ($urandom_range(0, 9) == 0);
      id_if_xcause = $urandom_range(0, 15);
      id_bubble    = $urandom_range(0, 1);
      sel_a = $urandom_range(0, 3);
      sel_b = $urandom_range(0, 3);
      src1 = $urandom;
      src2 = ($urandom_range(0, 2) == 0) ? src1 : $urandom;
      rf_a = ($urandom_range(0, 1) == 1) ? src1 : $urandom;
      rf_b = ($urandom_range(0, 2) == 0) ? rf_a : $urandom;
    end
    tick();
    rst = 0; id_valid = 0; flush = 0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mirfak_id_stage_hs.md
# mirfak_id_stage_hs

Parametrised, handshaked instruction-decode stage for the Mirfak pipeline, sitting between IF and EX. It reads the register file, resolves forwarding from a configurable number of sources, builds operands and immediates, and resolves branches/jumps in ID. It replaces the enable/clear IDEX register with a valid/ready interface backed by a 2-entry skid buffer, so back-pressure from EX never drops or duplicates an instruction.

## Interface
- NFWD, 2, number of forwarding sources (1..6); forwarding select width FW = $clog2(NFWD+1).
- C_EXT, 0, 1 = compressed ISA enabled: no branch/jump misalignment exception is raised.
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset; one clock, synchronous, active-high.
- id_valid_i  input  1  IF presents an instruction.
- id_ready_o  output  1  ID can accept this cycle; registered.
- id_pc_i, id_pc4_i, id_instruction_i  input  32 each  instruction payload.
- id_if_exception_i  input  1 ; id_if_xcause_i  input  4  fetch exception and cause.
- id_bubble_i  input  1  payload is a bubble.
- id_control_i  input  `CTRL_SZ  decoded control word.
- rf_raddr_a_o, rf_raddr_b_o  output  5  instruction[19:15] and [24:20].
- rf_rdata_a_i, rf_rdata_b_i  input  32  register file read data, same cycle.
- id_fwd_a_sel_i, id_fwd_b_sel_i  input  FW  0 = register file, k = source k.
- fwd_data_i  input  32*NFWD  source k at bits [32k-1 -: 32].
- flush_i  input  1  discard all held and incoming instructions.
- take_branch_o  output  1 ; pc_bj_target_o  output  32  redirect to IF.
- ex_valid_o  output  1 ; ex_ready_i  input  1  EX handshake.
- ex_pc_o, ex_pc4_o, ex_instruction_o, ex_mtval_o, ex_operand_a_o, ex_operand_b_o, ex_lsu_wdata_o  output  32 each.
- ex_exception_o  output  1 ; ex_xcause_o  output  4 ; ex_bubble_o  output  1 ; ex_control_o  output  `CTRL_SZ.

## Operation
- Accept = id_valid_i & id_ready_o & !flush_i. All combinational results are computed from the inputs on the accept cycle and captured; none are recomputed later.
- Forwarding: sel 0 = rf_rdata, 1..NFWD = fwd source, sel > NFWD = 32'h0 (never X).
- Immediates: I, S, B, U, J per RV32I, selected by `CTRL_SEL_IMM (000..100); other codes = 0.
- Operand A: A_RF/A_PC/A_PC4/A_ZERO; operand B: B_RF/B_IMM/B_4/B_ZERO. ex_lsu_wdata = forwarded B.
- Branch compare on forwarded A/B: eq, signed lt, unsigned lt against BEQ/BNE/BLT/BGE/BLTU/BGEU; IS_J = unconditional.
- Target: JALR (IS_J & instruction[3]=0) = (fwdA + imm_i) & ~1; otherwise pc + (IS_J ? imm_j : imm_b). 32-bit wrap-around, no overflow flag.
- take_branch_o = condition & Accept; never asserted on a non-accepted or flushed cycle.
- bj_error = take_branch_o & |target[1:0] & (C_EXT==0).
- Exception = if_exception | `CTRL_INVALID | bj_error. Priority: fetch (xcause = id_if_xcause_i, mtval = pc) > bj_error (E_INST_ADDR_MISALIGNED, mtval = target) > illegal (E_ILLEGAL_INST, mtval = instruction).
- Storage: output register (OUT) plus skid register (SKID). States: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
  - EMPTY: Accept -> ONE.
  - ONE: Accept & ex_ready_i -> ONE (new beat in OUT); Accept & !ex_ready_i -> FULL (beat in SKID); !Accept & ex_ready_i -> EMPTY.
  - FULL: ex_ready_i -> ONE (SKID moves to OUT); else hold.
- id_ready_o = 1 in EMPTY/ONE, 0 in FULL (registered from next state).
- flush_i: next state EMPTY regardless of ex_ready_i; incoming beat dropped; id_ready_o = 1 next cycle.
- Reset: state EMPTY; ex_valid_o 0, id_ready_o 1, ex_instruction_o 32'h00000013 (NOP), ex_bubble_o 1, all other ex_* outputs 0. Reset overrides flush and Accept.

## Timing
- Accept-to-ex_valid_o latency: 1 cycle. Sustained throughput 1 instr/cycle while ex_ready_i = 1.
- take_branch_o/pc_bj_target_o combinational, same cycle as Accept.
- ex_* payload stable while ex_valid_o & !ex_ready_i.
- id_ready_o falls the cycle after the stall-capturing Accept and rises the cycle after the FULL drain.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) accepted with ex_ready_i=1 -> next cycle ex_valid_o=1, ex_operand_b_o=5, ex_bubble_o per input.
- Three back-to-back instructions, ex_ready_i low for cycles 2-3 -> id_ready_o low after second accept, all three appear on EX in order, none lost or duplicated.
- BEQ with fwd sel A=1 (src1=7), sel B=2 (src2=7), pc=0x100, imm_b=+8 -> take_branch_o=1, target 0x108; with src2=8 -> take_branch_o=0.
- JALR fwdA=0x203, imm_i=0, C_EXT=0 -> target 0x202, ex_exception_o=1, xcause E_INST_ADDR_MISALIGNED, mtval 0x202; C_EXT=1 -> no exception.
- FULL state with flush_i=1 and id_valid_i=1 -> next cycle ex_valid_o=0, id_ready_o=1, take_branch_o=0 in flush cycle.
- Fetch exception on invalid control word -> xcause = id_if_xcause_i, mtval = pc (fetch wins priority).
